// File: rtl/mic_pdm_wrapper.sv
// PDM microphone capture slot: mic clock generator, count-of-ones decimator and PCM sample FIFO.
// Build option MIC_SIGNED_EN: samples are stored as ones-DECIM_LEN/2 and sign-extended on read.
module mic_pdm_wrapper #(
    parameter int CLK_DIV   = 50,
    parameter int DECIM_LEN = 128,
    parameter int DEPTH     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        mic_clk,
    output logic        mic_lrsel,
    input  logic        mic_data
);
    localparam int SW = $clog2(DECIM_LEN) + 1;
    localparam int BW = $clog2(DECIM_LEN);
    localparam int DW = $clog2(CLK_DIV);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DECIM_LEN - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic          enable_q, enable_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          mic_clk_q, mic_clk_d;
    logic          mic_clk_prev_q;
    logic [1:0]    sync_q;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [SW-1:0] ones_acc_q, ones_acc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [SW-1:0] mem_q [DEPTH];

    logic          ctrl_wr;
    logic          pop_req;
    logic          pop;
    logic          empty;
    logic          full;
    logic          strobe;
    logic          bit_in;
    logic          win_done;
    logic          flush;
    logic          push_ok;
    logic          ovf_set;
    logic [SW-1:0] sample_ones;
    logic [SW-1:0] sample_val;
    logic [SW-1:0] head;
    logic          unused_wr_bits;

    assign unused_wr_bits = ^wr_data[31:3];

    assign ctrl_wr = cs & write & (addr == 5'd2);
    assign pop_req = cs & read & (addr == 5'd0);
    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign pop     = pop_req & ~empty;
    assign flush   = ctrl_wr & wr_data[2];

    // Falling edge of the registered mic clock; gated so the forced low on disable is not a sample.
    assign strobe   = enable_q & mic_clk_prev_q & ~mic_clk_q;
    assign bit_in   = sync_q[1];
    assign win_done = strobe & (bit_cnt_q == BIT_LAST);

    assign sample_ones = ones_acc_q + SW'(bit_in);
`ifdef MIC_SIGNED_EN
    assign sample_val  = sample_ones - SW'(DECIM_LEN / 2);
`else
    assign sample_val  = sample_ones;
`endif

    // A flush in the same cycle swallows the finished sample without flagging overflow.
    assign push_ok = win_done & ~flush & (~full | pop);
    assign ovf_set = win_done & ~flush & full & ~pop;

    assign head      = mem_q[rd_ptr_q];
    assign mic_clk   = mic_clk_q;
    assign mic_lrsel = 1'b0;

    always_comb begin
        enable_d   = enable_q;
        div_cnt_d  = '0;
        mic_clk_d  = 1'b0;
        bit_cnt_d  = '0;
        ones_acc_d = '0;
        overflow_d = overflow_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (ctrl_wr) begin
            enable_d = wr_data[0];
        end

        if (enable_q) begin
            if (div_cnt_q == DIV_LAST) begin
                div_cnt_d = '0;
                mic_clk_d = ~mic_clk_q;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
                mic_clk_d = mic_clk_q;
            end

            bit_cnt_d  = bit_cnt_q;
            ones_acc_d = ones_acc_q;
            if (strobe) begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d  = '0;
                    ones_acc_d = '0;
                end else begin
                    bit_cnt_d  = bit_cnt_q + BW'(1);
                    ones_acc_d = sample_ones;
                end
            end
        end

        // Set takes priority so an overflow in the clearing cycle is not lost.
        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (ctrl_wr && wr_data[1]) begin
            overflow_d = 1'b0;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(push_ok);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            count_d  = count_q + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q       <= 1'b0;
            div_cnt_q      <= '0;
            mic_clk_q      <= 1'b0;
            mic_clk_prev_q <= 1'b0;
            sync_q         <= '0;
            bit_cnt_q      <= '0;
            ones_acc_q     <= '0;
            overflow_q     <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            enable_q       <= enable_d;
            div_cnt_q      <= div_cnt_d;
            mic_clk_q      <= mic_clk_d;
            mic_clk_prev_q <= mic_clk_q;
            sync_q         <= {sync_q[0], mic_data};
            bit_cnt_q      <= bit_cnt_d;
            ones_acc_q     <= ones_acc_d;
            overflow_q     <= overflow_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= sample_val;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            5'd0: begin
                if (!empty) begin
`ifdef MIC_SIGNED_EN
                    rd_data = {{(32 - SW){head[SW-1]}}, head};
`else
                    rd_data = {{(32 - SW){1'b0}}, head};
`endif
                end
            end
            5'd1: rd_data = {20'b0, enable_q, overflow_q, full, empty, 8'(count_q)};
            5'd2: rd_data = {31'b0, enable_q};
            default: rd_data = '0;
        endcase
    end
endmodule

// File: tb/tb_mic_pdm_wrapper.sv
// Directed bench for mic_pdm_wrapper: bus reads push expectations into a scoreboard
// that a negedge monitor pops and compares against rd_data.
`timescale 1ns/1ps
module tb_mic_pdm_wrapper;
    localparam int CLK_DIV   = 2;
    localparam int DECIM_LEN = 8;
    localparam int DEPTH     = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        mic_clk;
    logic        mic_lrsel;
    logic        mic_data;

    logic held_bit = 1'b0;
    logic alt_mode = 1'b0;
    logic alt_bit  = 1'b0;

    assign mic_data = alt_mode ? alt_bit : held_bit;

    mic_pdm_wrapper #(.CLK_DIV(CLK_DIV), .DECIM_LEN(DECIM_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .mic_clk(mic_clk), .mic_lrsel(mic_lrsel),
        .mic_data(mic_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Alternating pattern: one level change per mic clock period.
    always @(posedge mic_clk) if (alt_mode) alt_bit <= ~alt_bit;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (cs && read) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: read with no expectation queued, got 0x%08h", rd_data);
            end else begin
                e = sb_q.pop_front();
                chk(e.name, rd_data, e.exp);
            end
        end
    end

    task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        addr = a;
        cs   = 1'b1;
        read = 1'b1;
        @(posedge clk);
        #1;
        cs   = 1'b0;
        read = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        cs      = 1'b1;
        write   = 1'b1;
        @(posedge clk);
        #1;
        cs    = 1'b0;
        write = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] smp(input int ones);
`ifdef MIC_SIGNED_EN
        return 32'(ones - DECIM_LEN / 2);
`else
        return 32'(ones);
`endif
    endfunction

    // Sample appears on edge e0+33 after an enable write (8 strobes spaced 4 clk, first at e0+4).
    task automatic run_window(input logic held, input logic alt, input int ones, input string nm);
        int e0;
        bus_write(2, 32'h4);
        held_bit = held;
        alt_mode = alt;
        wait_until(cyc + 4);
        bus_write(2, 32'h1);
        e0 = cyc;
        wait_until(e0 + 30);
        bus_read(1, 32'h900, {nm, "_early"});
        wait_until(e0 + 36);
        bus_read(1, 32'h801, {nm, "_status"});
        bus_read(0, smp(ones), {nm, "_sample"});
        bus_write(2, 32'h4);
        alt_mode = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   e0;
    int   r0;
    int   r1;
    int   hi;
    logic prev;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mic_clk", 32'(mic_clk), 32'h0);
        chk("rst_lrsel", 32'(mic_lrsel), 32'h0);
        bus_read(1, 32'h100, "rst_status");
        bus_read(2, 32'h0, "rst_ctrl");
        bus_read(0, 32'h0, "rst_head");
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus_read(7, 32'h0, "unmapped_rd");
        bus_write(7, 32'hFFFF_FFFF);
        bus_read(1, 32'h100, "unmapped_wr_ignored");

        // Mic clock: period 4 clk, high 2 clk
        bus_write(2, 32'h1);
        bus_read(2, 32'h1, "ctrl_en");
        r0 = -1;
        r1 = -1;
        hi = 0;
        prev = mic_clk;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mic_clk && !prev) begin
                if (r0 < 0) r0 = i;
                else if (r1 < 0) r1 = i;
            end
            if (r0 >= 0 && r1 < 0 && mic_clk) hi++;
            prev = mic_clk;
        end
        @(posedge clk);
        #1;
        chk("mic_clk_two_rises", 32'(r1 >= 0), 32'h1);
        chk("mic_clk_period", 32'(r1 - r0), 32'd4);
        chk("mic_clk_high", 32'(hi), 32'd2);
        bus_write(2, 32'h4);
        bus_read(1, 32'h100, "dis_status");

        // Decimation of held and alternating patterns
        run_window(1'b1, 1'b0, 8, "ones");
        run_window(1'b0, 1'b0, 0, "zeros");
        run_window(1'b0, 1'b1, 4, "alt");

        // Fill, overflow, clear, push+pop at full. Windows: 8,0,0,0,(8 dropped),8
        bus_write(2, 32'h4);
        held_bit = 1'b1;
        wait_until(cyc + 4);
        bus_write(2, 32'h1);
        e0 = cyc;
        wait_until(e0 + 33);
        held_bit = 1'b0;
        wait_until(e0 + 129);
        held_bit = 1'b1;
        wait_until(e0 + 140);
        bus_read(1, 32'hA04, "full_status");
        wait_until(e0 + 165);
        bus_read(1, 32'hE04, "ovf_status");
        bus_write(2, 32'h3);
        bus_read(1, 32'hA04, "ovf_clear");
        wait_until(e0 + 192);
        bus_read(0, smp(8), "full_pushpop_head");
        bus_read(1, 32'hA04, "full_pushpop_count");
        bus_write(2, 32'h0);
        bus_read(0, smp(0), "fifo_order0");
        bus_read(0, smp(0), "fifo_order1");
        bus_read(0, smp(0), "fifo_order2");
        bus_read(0, smp(8), "fifo_order3_tail");
        bus_read(1, 32'h100, "drained_status");

        // Empty read, flush with three entries and a coincident push
        bus_read(0, 32'h0, "empty_head");
        bus_read(1, 32'h100, "empty_no_pop");
        held_bit = 1'b1;
        wait_until(cyc + 4);
        bus_write(2, 32'h1);
        e0 = cyc;
        wait_until(e0 + 110);
        bus_read(1, 32'h803, "three_status");
        wait_until(e0 + 128);
        bus_write(2, 32'h5);
        bus_read(1, 32'h900, "flush_status");
        wait_until(e0 + 162);
        bus_read(1, 32'h801, "post_flush_status");
        bus_read(0, smp(8), "post_flush_sample");

        // Disable after 5 one-bits, re-enable with zeros: fresh window expected
        bus_write(2, 32'h4);
        held_bit = 1'b1;
        wait_until(cyc + 4);
        bus_write(2, 32'h1);
        e0 = cyc;
        wait_until(e0 + 22);
        bus_write(2, 32'h0);
        held_bit = 1'b0;
        wait_until(cyc + 4);
        bus_write(2, 32'h1);
        e0 = cyc;
        wait_until(e0 + 30);
        bus_read(1, 32'h900, "reen_early");
        wait_until(e0 + 36);
        bus_read(1, 32'h801, "reen_status");
        bus_read(0, smp(0), "reen_sample");

        // Asynchronous reset while mic_clk is high and the FIFO holds a sample
        wait_until(e0 + 68);
        bus_read(1, 32'h801, "pre_rst_status");
        wait_until(e0 + 70);
        chk("pre_rst_mic_clk", 32'(mic_clk), 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_async_mic_clk", 32'(mic_clk), 32'h0);
        chk("rst_async_lrsel", 32'(mic_lrsel), 32'h0);
        bus_read(1, 32'h100, "rst_async_status");
        bus_read(2, 32'h0, "rst_async_ctrl");
        reset = 1'b0;
        wait_until(cyc + 10);
        chk("post_rst_mic_clk_idle", 32'(mic_clk), 32'h0);
        bus_read(1, 32'h100, "post_rst_status");

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mic_pdm_wrapper.md
Name: mic_pdm_wrapper

Overview:
Slot-bus peripheral for the on-board PDM MEMS microphone; the capture-side counterpart of the speaker PDM output slot. It generates the microphone clock and samples the 1-bit PDM stream. It decimates the stream by counting ones over a fixed window and buffers the resulting PCM samples in a FIFO. The processor reads the FIFO and status through the standard slot interface (cs/read/write/addr/wr_data/rd_data).

Parameters:
CLK_DIV, 50, clk cycles per mic_clk half-period (mic_clk = clk/(2*CLK_DIV); 1 MHz at 100 MHz); must be >=2
DECIM_LEN, 128, PDM bits per PCM sample; power of 2, 8..1024
DEPTH, 16, FIFO entries; power of 2, 2..128

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cs  in  1  slot select
read  in  1  slot read strobe
write  in  1  slot write strobe
addr  in  5  slot register address
wr_data  in  32  slot write data
rd_data  out  32  slot read data (combinational from addr)
mic_clk  out  1  microphone clock
mic_lrsel  out  1  channel select, tied 0
mic_data  in  1  PDM data from microphone (asynchronous)

Behaviour:
- Reset: mic_clk=0, mic_lrsel=0, enable=0, FIFO empty, overflow=0, all counters 0. rd_data follows addr (status reads 0x100: empty=1).
- Register map (word addr):
  0 R: FIFO head sample, zero-extended, SW=$clog2(DECIM_LEN)+1 bits. A read with cs&&read pops one entry. Empty FIFO: returns 0, no pop.
  1 R: [7:0] count, [8] empty, [9] full, [10] overflow, [11] enable, rest 0.
  2 R/W: write bit0=enable, bit1=1 clears overflow (self-clearing), bit2=1 flushes FIFO (self-clearing). Read returns {31'b0, enable}.
  Other addresses: read 0, writes ignored.
- Clock gen: div_cnt runs 0..CLK_DIV-1 while enable=1. At CLK_DIV-1 it wraps and mic_clk toggles. enable=0: div_cnt=0, mic_clk held 0.
- Input: mic_data passes a 2-flop synchronizer. A sample strobe fires on the clk cycle where mic_clk is registered 1->0. The synchronized bit is taken that cycle.
- Decimator: bit_cnt counts 0..DECIM_LEN-1 and ones_acc adds the bit. On the strobe with bit_cnt=DECIM_LEN-1, it pushes ones_acc+bit (range 0..DECIM_LEN) and clears both. First sample is pushed DECIM_LEN*2*CLK_DIV clk cycles after enable rises, +/-1 cycle.
- Enable 1->0 mid-window: partial window discarded, bit_cnt/ones_acc cleared. FIFO contents kept.
- FIFO: pointers wrap mod DEPTH. count width $clog2(DEPTH)+1.
  Push when full with no pop in the same cycle: sample dropped, overflow set (sticky).
  Push and pop in the same cycle: both happen, count unchanged, including at full and at empty+push (pop is ignored when empty).
  Flush: pointers and count to 0 next cycle. A push in the same cycle is discarded.
  Clear overflow in the same cycle as a new overflow: overflow stays 1.
- Reset mid-operation: everything returns to reset values immediately (async).

Optional Feature:
MIC_SIGNED_EN.
- Defined: each pushed sample is ones-DECIM_LEN/2 in two's complement, SW bits, range -DECIM_LEN/2..+DECIM_LEN/2. On the bus it is sign-extended to 32 bits.
- Undefined: unsigned count, zero-extended.
- Status and control are identical in both builds.

Test Plan (CLK_DIV=2, DECIM_LEN=8, DEPTH=4 unless noted):
1. Reset, then read addr1 -> 0x100. Write addr2=1 -> mic_clk toggles every 2 clk, period 4 clk.
2. mic_data held 1, enable -> first sample 8 appears about 32 clk after enable. Held 0 -> 0. Alternating 1/0 per mic_clk -> 4. With MIC_SIGNED_EN: 4, -4 (0xFFFFFFFC), 0.
3. Leave enabled without reading -> count reaches 4 and full=1, then overflow=1 and the FIFO holds the first 4 samples. Write addr2=0x3 -> overflow=0, enable stays 1.
4. FIFO full and a read of addr0 in the same cycle as a push -> count stays 4, the oldest sample is returned, the new sample is at the tail.
5. Read addr0 on empty -> 0, count stays 0. Write addr2=0x5 with 3 entries -> count=0 next cycle.
6. Disable at bit_cnt=5, then re-enable -> next sample covers a fresh 8-bit window. Assert reset mid-window -> all outputs return to reset values in the same cycle.
